// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed 6-digit common-anode 7-segment driver for HH:MM:SS.
//   Ports: clk, rst_n (async, active-low); bcd_in[23:0]/bcd_valid/bcd_ack handshake
//   for the packed BCD time; edit_sel[1:0] picks the blinking field (0 none, 1 sec,
//   2 min, 3 hr); enable=0 blanks the display; seg_n[6:0] (g..a) and dig_n[5:0] are
//   active-low registered outputs; frame_start pulses when the scan wraps 5 -> 0.
//   Optional macro HEX_SCAN_LZ_BLANK_EN blanks a leading zero in the hour-tens digit.
module hex_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ack,
    input  logic [1:0]  edit_sel,
    input  logic        enable,
    output logic [6:0]  seg_n,
    output logic [5:0]  dig_n,
    output logic        frame_start
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [23:0]   disp;
    logic [23:0]   pend_val;
    logic          pend;
    logic          blink_phase;
    logic [BW-1:0] blink_cnt;

    logic          slot_end;
    logic          wrap;
    logic          capture;
    logic          guard;
    logic          blank;
    logic          lz;
    logic [3:0]    nib;
    logic [6:0]    seg_lut;
    logic [6:0]    seg_next;
    logic [5:0]    dig_next;

    always_comb begin
        slot_end = scan_cnt == SW'(SCAN_DIV - 1);
        wrap     = slot_end && idx == 3'd5;
        capture  = bcd_valid && !bcd_ack;
        guard    = int'(scan_cnt) < GUARD;
        nib      = 4'(disp >> {idx, 2'b00});
        // digits pair up per field: idx[2:1] is 0 for sec, 1 for min, 2 for hr
        blank    = blink_phase && edit_sel != 2'd0 && {1'b0, idx[2:1]} == {1'b0, edit_sel - 2'd1};
`ifdef HEX_SCAN_LZ_BLANK_EN
        lz       = idx == 3'd5 && nib == 4'd0;
`else
        lz       = 1'b0;
`endif
        case (nib)
            4'd0:    seg_lut = 7'b1000000;
            4'd1:    seg_lut = 7'b1111001;
            4'd2:    seg_lut = 7'b0100100;
            4'd3:    seg_lut = 7'b0110000;
            4'd4:    seg_lut = 7'b0011001;
            4'd5:    seg_lut = 7'b0010010;
            4'd6:    seg_lut = 7'b0000010;
            4'd7:    seg_lut = 7'b1111000;
            4'd8:    seg_lut = 7'b0000000;
            4'd9:    seg_lut = 7'b0010000;
            default: seg_lut = 7'b1111111;
        endcase
        seg_next = (!enable || guard || blank || lz) ? 7'h7F : seg_lut;
        dig_next = (!enable || guard) ? 6'h3F : ~(6'd1 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            idx         <= 3'd0;
            disp        <= 24'd0;
            pend_val    <= 24'd0;
            pend        <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
            bcd_ack     <= 1'b0;
            frame_start <= 1'b0;
            seg_n       <= 7'h7F;
            dig_n       <= 6'h3F;
        end else begin
            scan_cnt    <= slot_end ? '0 : scan_cnt + SW'(1);
            if (slot_end)
                idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            frame_start <= wrap;
            bcd_ack     <= capture;
            seg_n       <= seg_next;
            dig_n       <= dig_next;
            if (capture)
                pend_val <= bcd_in;
            // swap takes the pre-edge pending value; a coincident capture stays pending
            if (wrap && pend)
                disp <= pend_val;
            pend <= capture || (pend && !wrap);
            if (wrap) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end
endmodule
